// File: rtl/game_pkg.sv
// Shared types and constants for the game tick scheduler.
// The speed ramp is enabled by defining GAME_TICK_SPEEDUP_EN.
package game_pkg;

  localparam int unsigned PERIOD_W = 16;
  localparam int unsigned RAMP_W   = 8;
  localparam int unsigned STATE_W  = 2;

  localparam logic [PERIOD_W-1:0] PERIOD_INIT_DEF   = 16'd50000;
  localparam logic [PERIOD_W-1:0] PERIOD_MIN_DEF    = 16'd20000;
  localparam logic [PERIOD_W-1:0] SPEEDUP_STEP_DEF  = 16'd500;
  localparam logic [RAMP_W-1:0]   SPEEDUP_EVERY_DEF = 8'd200;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_e;

  // A zero period would never tick; treat it as one cycle.
  function automatic logic [PERIOD_W-1:0] sanitize_period(input logic [PERIOD_W-1:0] p);
    return (p == '0) ? PERIOD_W'(1) : p;
  endfunction

  // Step the period toward the floor without wrapping below it.
  function automatic logic [PERIOD_W-1:0] ramp_period(input logic [PERIOD_W-1:0] p,
                                                      input logic [PERIOD_W-1:0] step,
                                                      input logic [PERIOD_W-1:0] floor);
    if (p <= floor)             return p;
    else if (p - floor <= step) return floor;
    else                        return p - step;
  endfunction

endpackage

// File: rtl/game_tick_sched_if.sv
// Control/status bundle between game-control logic and the tick scheduler.
interface game_tick_sched_if;
  import game_pkg::*;

  logic                start;
  logic                pause;
  logic                resume;
  logic                stop;
  logic                cfg_we;
  logic [PERIOD_W-1:0] cfg_period;
  logic                tick;
  logic                running;
  logic [STATE_W-1:0]  state;
  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] tick_count;

  modport master (
    output start, pause, resume, stop, cfg_we, cfg_period,
    input  tick, running, state, period, tick_count
  );

  modport slave (
    input  start, pause, resume, stop, cfg_we, cfg_period,
    output tick, running, state, period, tick_count
  );
endinterface

// File: rtl/tick_prescaler.sv
// 16-bit down-counter with synchronous load, count enable and zero flag.
module tick_prescaler
  import game_pkg::*;
(
  input  logic                clk,
  input  logic                clear,
  input  logic                load,
  input  logic [PERIOD_W-1:0] load_val,
  input  logic                en,
  output logic                zero_c
);

  logic [PERIOD_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!clear)                cnt_q <= '0;
    else if (load)             cnt_q <= load_val;
    else if (en && !zero_c)    cnt_q <= cnt_q - PERIOD_W'(1);
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/game_tick_sched.sv
// Game tick scheduler: run/pause FSM around a programmable prescaler.
// Optional speed ramp under GAME_TICK_SPEEDUP_EN.
module game_tick_sched
  import game_pkg::*;
#(
  parameter logic [PERIOD_W-1:0] PERIOD_INIT = PERIOD_INIT_DEF
`ifdef GAME_TICK_SPEEDUP_EN
  , parameter logic [PERIOD_W-1:0] PERIOD_MIN    = PERIOD_MIN_DEF
  , parameter logic [PERIOD_W-1:0] SPEEDUP_STEP  = SPEEDUP_STEP_DEF
  , parameter logic [RAMP_W-1:0]   SPEEDUP_EVERY = SPEEDUP_EVERY_DEF
`endif
) (
  input  logic              clk,
  input  logic              clear,
  game_tick_sched_if.slave  bus
);

  state_e              state_q, state_d;
  logic                tick_q, tick_d;
  logic                running_q, running_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] tick_count_q, tick_count_d;
  logic                ld, en, zero_c;
  logic [PERIOD_W-1:0] ld_val;

`ifdef GAME_TICK_SPEEDUP_EN
  localparam logic [RAMP_W-1:0] EVERY_EFF = (SPEEDUP_EVERY == '0) ? RAMP_W'(1) : SPEEDUP_EVERY;
  logic [RAMP_W-1:0] ramp_q, ramp_d, ramp_inc;
  assign ramp_inc = ramp_q + RAMP_W'(1);
`endif

  tick_prescaler u_prescaler (
    .clk      (clk),
    .clear    (clear),
    .load     (ld),
    .load_val (ld_val),
    .en       (en),
    .zero_c   (zero_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!clear) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state: stop beats pause beats resume/start
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!bus.stop && bus.start) state_d = ST_RUN;
      ST_RUN:   if (bus.stop)               state_d = ST_IDLE;
                else if (bus.pause)         state_d = ST_PAUSE;
      ST_PAUSE: if (bus.stop)               state_d = ST_IDLE;
                else if (bus.resume)        state_d = ST_RUN;
      default:                              state_d = ST_IDLE;
    endcase
  end

  // Datapath controls and next values of the registered outputs
  always_comb begin
    ld           = 1'b0;
    ld_val       = '0;
    en           = 1'b0;
    tick_d       = 1'b0;
    tick_count_d = tick_count_q;
    period_d     = period_q;
`ifdef GAME_TICK_SPEEDUP_EN
    ramp_d       = ramp_q;
`endif
    running_d    = (state_d == ST_RUN);
    case (state_q)
      ST_IDLE: begin
        if (bus.cfg_we) period_d = sanitize_period(bus.cfg_period);
        if (!bus.stop && bus.start) begin
          ld           = 1'b1;
          ld_val       = period_d - PERIOD_W'(1);
          tick_count_d = '0;
`ifdef GAME_TICK_SPEEDUP_EN
          ramp_d       = '0;
`endif
        end
      end
      ST_RUN: begin
        if (bus.stop) begin
          ld = 1'b1;
        end else if (!zero_c) begin
          en = 1'b1;
        end else if (!bus.pause) begin
          // Terminal count: reload with the current period, new period applies next reload
          ld           = 1'b1;
          ld_val       = period_q - PERIOD_W'(1);
          tick_d       = 1'b1;
          tick_count_d = tick_count_q + PERIOD_W'(1);
`ifdef GAME_TICK_SPEEDUP_EN
          if (ramp_inc >= EVERY_EFF) begin
            ramp_d   = '0;
            period_d = ramp_period(period_q, SPEEDUP_STEP, PERIOD_MIN);
          end else begin
            ramp_d   = ramp_inc;
          end
`endif
        end
      end
      ST_PAUSE: begin
        if (bus.stop) ld = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clear) begin
      tick_q       <= 1'b0;
      running_q    <= 1'b0;
      period_q     <= PERIOD_INIT;
      tick_count_q <= '0;
`ifdef GAME_TICK_SPEEDUP_EN
      ramp_q       <= '0;
`endif
    end else begin
      tick_q       <= tick_d;
      running_q    <= running_d;
      period_q     <= period_d;
      tick_count_q <= tick_count_d;
`ifdef GAME_TICK_SPEEDUP_EN
      ramp_q       <= ramp_d;
`endif
    end
  end

  assign bus.tick       = tick_q;
  assign bus.running    = running_q;
  assign bus.state      = state_q;
  assign bus.period     = period_q;
  assign bus.tick_count = tick_count_q;

endmodule

// File: tb/tb_game_tick_sched.sv
// Directed bench for game_tick_sched; ramp vectors run when GAME_TICK_SPEEDUP_EN is defined.
module tb_game_tick_sched;

`ifdef GAME_TICK_SPEEDUP_EN
  localparam logic [15:0] P_INIT = 16'd10;
`else
  localparam logic [15:0] P_INIT = 16'd50000;
`endif

  logic clk = 1'b0;
  logic clear = 1'b0;
  int   n_cmp = 0;
  int   n_mis = 0;

  always #5 clk = ~clk;

  game_tick_sched_if bus();

`ifdef GAME_TICK_SPEEDUP_EN
  game_tick_sched #(
    .PERIOD_INIT   (16'd10),
    .PERIOD_MIN    (16'd6),
    .SPEEDUP_STEP  (16'd3),
    .SPEEDUP_EVERY (8'd2)
  ) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );
`else
  game_tick_sched dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Edges until tick is seen; returns lim when it never appears
  task automatic wait_tick(input int lim, output int n);
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (!bus.tick && n < lim);
  endtask

  int n;
  int hits;
  int misses;
`ifdef GAME_TICK_SPEEDUP_EN
  int exp_gap [6] = '{10, 10, 10, 7, 7, 6};
  int exp_per [6] = '{10, 7, 7, 6, 6, 6};
`endif

  initial begin
    bus.start = 1'b0; bus.pause = 1'b0; bus.resume = 1'b0; bus.stop = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_period = '0;
    clear = 1'b0;
    cyc(2);
    chk("rst_state", bus.state, 2'b00);
    chk("rst_tick", bus.tick, 1'b0);
    chk("rst_running", bus.running, 1'b0);
    chk("rst_count", bus.tick_count, 16'd0);
    chk("rst_period", bus.period, P_INIT);
    clear = 1'b1;

`ifdef GAME_TICK_SPEEDUP_EN
    bus.start = 1'b1; cyc(1); bus.start = 1'b0;
    chk("ramp_state", bus.state, 2'b01);
    for (int i = 0; i < 6; i++) begin
      wait_tick(50, n);
      chk("ramp_gap", n, exp_gap[i]);
      chk("ramp_period", bus.period, exp_per[i]);
    end
`else
    // Basic ticking with period 4
    bus.cfg_we = 1'b1; bus.cfg_period = 16'd4; cyc(1); bus.cfg_we = 1'b0;
    chk("cfg_period", bus.period, 16'd4);
    bus.start = 1'b1; cyc(1); bus.start = 1'b0;
    chk("start_state", bus.state, 2'b01);
    chk("start_running", bus.running, 1'b1);
    chk("start_count", bus.tick_count, 16'd0);
    for (int i = 0; i < 5; i++) begin
      wait_tick(20, n);
      chk("gap4", n, 4);
    end
    chk("count5", bus.tick_count, 16'd5);
    cyc(1);
    chk("tick_width", bus.tick, 1'b0);

    // Pause mid-count
    bus.pause = 1'b1; cyc(1); bus.pause = 1'b0;
    chk("pause_state", bus.state, 2'b10);
    chk("pause_running", bus.running, 1'b0);
    hits = 0;
    repeat (10) begin cyc(1); hits += int'(bus.tick); end
    chk("pause_quiet", hits, 0);
    bus.resume = 1'b1; cyc(1); bus.resume = 1'b0;
    chk("resume_state", bus.state, 2'b01);
    wait_tick(20, n);
    chk("resume_gap", n, 2);
    chk("count6", bus.tick_count, 16'd6);

    // Pause on the terminal edge
    cyc(3);
    bus.pause = 1'b1; cyc(1); bus.pause = 1'b0;
    chk("pz_tick", bus.tick, 1'b0);
    chk("pz_state", bus.state, 2'b10);
    cyc(3);
    bus.resume = 1'b1; cyc(1); bus.resume = 1'b0;
    wait_tick(20, n);
    chk("pz_gap", n, 1);
    chk("count7", bus.tick_count, 16'd7);

    // Config lockout in RUN
    bus.cfg_we = 1'b1; bus.cfg_period = 16'd9; cyc(1); bus.cfg_we = 1'b0;
    chk("lockout", bus.period, 16'd4);
    wait_tick(20, n);
    chk("lockout_gap", n, 3);

    // Stop on the terminal edge
    cyc(3);
    bus.stop = 1'b1; cyc(1); bus.stop = 1'b0;
    chk("stop_tick", bus.tick, 1'b0);
    chk("stop_state", bus.state, 2'b00);
    chk("stop_running", bus.running, 1'b0);
    cyc(5);
    chk("stop_count_hold", bus.tick_count, 16'd8);

    // Restart clears the count
    bus.start = 1'b1; cyc(1); bus.start = 1'b0;
    chk("restart_count", bus.tick_count, 16'd0);
    wait_tick(20, n);
    chk("restart_gap", n, 4);
    chk("restart_count1", bus.tick_count, 16'd1);
    bus.stop = 1'b1; cyc(1); bus.stop = 1'b0;

    // Period 0 written together with start: period 1, tick every cycle, count wraps
    bus.cfg_we = 1'b1; bus.cfg_period = 16'd0; bus.start = 1'b1; cyc(1);
    bus.cfg_we = 1'b0; bus.start = 1'b0;
    chk("p0_period", bus.period, 16'd1);
    chk("p0_count", bus.tick_count, 16'd0);
    misses = 0;
    for (int k = 0; k < 65535; k++) begin
      cyc(1);
      if (!bus.tick) misses++;
    end
    chk("wrap_ffff", bus.tick_count, 16'hFFFF);
    cyc(1);
    chk("wrap_tick", bus.tick, 1'b1);
    chk("wrap_zero", bus.tick_count, 16'h0000);
    chk("p1_every_cycle", misses, 0);
    chk("wrap_period", bus.period, 16'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
